// File: rtl/seq_signed_mult_bcd_if.sv
// Operand/result bundle for the signed BCD multiplier: start handshake, scroll pulses, result and window.
interface seq_signed_mult_bcd_if #(
   parameter int WIDTH = 8,
   parameter int WIN   = 3
);
   logic                 start;
   logic [WIDTH-1:0]     multiplier;
   logic [WIDTH-1:0]     multiplicand;
   logic                 scroll_left;
   logic                 scroll_right;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;
   logic                 sign;
   logic [4*WIN-1:0]     win_digits;
   logic                 at_lsd;
   logic                 at_msd;

   modport master (
      output start, multiplier, multiplicand, scroll_left, scroll_right,
      input  busy, done, product, sign, win_digits, at_lsd, at_msd
   );

   modport slave (
      input  start, multiplier, multiplicand, scroll_left, scroll_right,
      output busy, done, product, sign, win_digits, at_lsd, at_msd
   );
endinterface

// File: rtl/seq_signed_mult_bcd.sv
// Sequential signed multiply (early-out shift-add) then double-dabble to NDIG BCD digits with a scrollable window.
// Latency bitlen(|multiplier|) + 2*WIDTH edges to done; start while busy is dropped, scrolling accepted any time.
module seq_signed_mult_bcd #(
   parameter int WIDTH = 8,
   parameter int NDIG  = 5,
   parameter int WIN   = 3
) (
   input  logic sys_clk,
   input  logic rst,
   seq_signed_mult_bcd_if.slave bus
);
   localparam int PW   = 2*WIDTH - 1;
   localparam int DW   = 4*NDIG;
   localparam int PMAX = NDIG - WIN;
   localparam int POSW = (PMAX > 0) ? $clog2(PMAX + 1) : 1;
   localparam int CW   = $clog2(2*WIDTH);
   localparam logic [CW-1:0]   LAST     = CW'(2*WIDTH - 2);
   localparam logic [POSW-1:0] POS_MAX  = POSW'(PMAX);

   typedef enum logic [1:0] {IDLE, MUL, BCD, DONE} state_t;

   state_t state, state_n;

   logic [WIDTH-1:0]   mplier;
   logic [PW-1:0]      mcand;
   logic [PW-1:0]      acc;
   logic               psign;
   logic [DW-1:0]      bcd, bcd_sh, adj;
   logic [PW-1:0]      bin, bin_sh;
   logic [CW-1:0]      cnt;
   logic [DW-1:0]      digits;
   logic [POSW-1:0]    pos;
   logic [2*WIDTH-1:0] product_r;
   logic               sign_r;

   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [2*WIDTH-1:0] mag;
   logic               neg;
   logic               commit;
   logic [DW-1:0]      win_sh;

   assign abs_a  = bus.multiplier[WIDTH-1]   ? (~bus.multiplier + 1'b1)   : bus.multiplier;
   assign abs_b  = bus.multiplicand[WIDTH-1] ? (~bus.multiplicand + 1'b1) : bus.multiplicand;
   assign mag    = {1'b0, acc};
   assign neg    = psign && (acc != '0);
   assign commit = (state == BCD) && (cnt == LAST);

   always_ff @(posedge sys_clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.start) state_n = MUL;
         MUL:     if (mplier == '0) state_n = BCD;
         BCD:     if (cnt == LAST) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // One double-dabble step: correct digits >= 5, then shift the whole digit:binary chain left.
   always_comb begin
      adj = bcd;
      for (int i = 0; i < NDIG; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      bcd_sh = {adj[DW-2:0], bin[PW-1]};
      bin_sh = {bin[PW-2:0], 1'b0};
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         mplier    <= '0;
         mcand     <= '0;
         acc       <= '0;
         psign     <= 1'b0;
         bcd       <= '0;
         bin       <= '0;
         cnt       <= '0;
         digits    <= '0;
         product_r <= '0;
         sign_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  mplier <= abs_a;
                  mcand  <= {{(PW-WIDTH){1'b0}}, abs_b};
                  acc    <= '0;
                  psign  <= bus.multiplier[WIDTH-1] ^ bus.multiplicand[WIDTH-1];
               end
            end
            MUL: begin
               if (mplier == '0) begin
                  bcd <= '0;
                  bin <= acc;
                  cnt <= '0;
               end else begin
                  if (mplier[0]) acc <= acc + mcand;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
               end
            end
            BCD: begin
               bcd <= bcd_sh;
               bin <= bin_sh;
               cnt <= cnt + 1'b1;
               if (commit) begin
                  digits    <= bcd_sh;
                  sign_r    <= neg;
                  product_r <= neg ? (~mag + 1'b1) : mag;
               end
            end
            default: ;
         endcase
      end
   end

   // A commit resets the window even if a scroll arrives on the same edge.
   always_ff @(posedge sys_clk) begin
      if (rst || commit) begin
         pos <= '0;
      end else if (bus.scroll_left && !bus.scroll_right && (pos != POS_MAX)) begin
         pos <= pos + 1'b1;
      end else if (bus.scroll_right && !bus.scroll_left && (pos != '0)) begin
         pos <= pos - 1'b1;
      end
   end

   assign win_sh         = digits >> {pos, 2'b00};
   assign bus.win_digits = win_sh[4*WIN-1:0];
   assign bus.at_lsd     = (pos == '0);
   assign bus.at_msd     = (pos == POS_MAX);
   assign bus.busy       = (state != IDLE);
   assign bus.done       = (state == DONE);
   assign bus.product    = product_r;
   assign bus.sign       = sign_r;
endmodule

// File: tb/tb_seq_signed_mult_bcd.sv
// Bench for seq_signed_mult_bcd (WIDTH=8, NDIG=5, WIN=3): vector table plus scoreboard, scroll/restart/reset corners.
module tb_seq_signed_mult_bcd;
   logic sys_clk = 1'b0;
   logic rst;

   always #5 sys_clk = ~sys_clk;

   seq_signed_mult_bcd_if #(.WIDTH(8), .WIN(3)) bus ();

   seq_signed_mult_bcd #(.WIDTH(8), .NDIG(5), .WIN(3)) dut (
      .sys_clk (sys_clk),
      .rst     (rst),
      .bus     (bus)
   );

   typedef struct {
      logic [15:0] prod;
      logic [11:0] win;
      int          l;
   } exp_t;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] prod;
      logic [11:0] win;
      int          l;
   } vec_t;

   exp_t sb[$];
   vec_t vt[9];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   function automatic exp_t model(input logic signed [7:0] a, input logic signed [7:0] b);
      exp_t e;
      int   p, m, ma, k;
      p  = int'(a) * int'(b);
      m  = (p < 0) ? -p : p;
      ma = (a < 0) ? -int'(a) : int'(a);
      k  = 0;
      while (ma != 0) begin
         k++;
         ma = ma >> 1;
      end
      e.prod = p[15:0];
      e.win  = {4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
      e.l    = k + 16;
      return e;
   endfunction

   // Entered and left at #1 after a rising edge; start is sampled on edge 0.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int inj_edge, input int scr_edge);
      exp_t e;
      int   got_l;
      bus.multiplier   = a;
      bus.multiplicand = b;
      bus.start        = 1'b1;
      @(posedge sys_clk); #1;
      bus.start = 1'b0;
      got_l = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge sys_clk); #1;
         if (n == 1) chk("busy_edge1", 32'(bus.busy), 32'd1);
         if (n == inj_edge) bus.start = 1'b0;
         if (n == scr_edge) bus.scroll_left = 1'b0;
         if (bus.done) begin
            got_l = n;
            break;
         end
         if (n == inj_edge - 1) begin
            bus.multiplier   = 8'd3;
            bus.multiplicand = 8'd3;
            bus.start        = 1'b1;
         end
         if (n == scr_edge - 1) bus.scroll_left = 1'b1;
      end
      bus.start       = 1'b0;
      bus.scroll_left = 1'b0;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      if (got_l < 0) begin
         chk("done_timeout", 32'hFFFFFFFF, 32'(e.l));
         return;
      end
      chk("done_edge",  32'(got_l),          32'(e.l));
      chk("product",    32'(bus.product),    32'(e.prod));
      chk("sign",       32'(bus.sign),       32'(e.prod[15]));
      chk("win_digits", 32'(bus.win_digits), 32'(e.win));
      chk("at_lsd",     32'(bus.at_lsd),     32'd1);
      @(posedge sys_clk); #1;
      chk("done_drop",  32'(bus.done),       32'd0);
      chk("busy_drop",  32'(bus.busy),       32'd0);
   endtask

   task automatic scroll(input logic l, input logic r, input logic [11:0] w, input string name);
      bus.scroll_left  = l;
      bus.scroll_right = r;
      @(posedge sys_clk); #1;
      bus.scroll_left  = 1'b0;
      bus.scroll_right = 1'b0;
      chk(name, 32'(bus.win_digits), 32'(w));
   endtask

   initial begin
      int dn;
      vt[0] = '{8'h80, 8'h80, 16'h4000, 12'h384, 24};
      vt[1] = '{8'd3,  8'hFB, 16'hFFF1, 12'h015, 18};
      vt[2] = '{8'd0,  8'hF9, 16'h0000, 12'h000, 16};
      vt[3] = '{8'd127, 8'd127, 16'h3F01, 12'h129, 23};
      vt[4] = '{8'd2,  8'd2,  16'h0004, 12'h004, 18};
      vt[5] = '{8'hFF, 8'd1,  16'hFFFF, 12'h001, 17};
      vt[6] = '{8'd100, 8'd100, 16'h2710, 12'h000, 23};
      vt[7] = '{8'h80, 8'd127, 16'hC080, 12'h256, 24};
      vt[8] = '{8'hFB, 8'd0,  16'h0000, 12'h000, 19};

      rst              = 1'b1;
      bus.start        = 1'b0;
      bus.multiplier   = '0;
      bus.multiplicand = '0;
      bus.scroll_left  = 1'b0;
      bus.scroll_right = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      chk("rst_busy",    32'(bus.busy),       32'd0);
      chk("rst_done",    32'(bus.done),       32'd0);
      chk("rst_product", 32'(bus.product),    32'd0);
      chk("rst_sign",    32'(bus.sign),       32'd0);
      chk("rst_win",     32'(bus.win_digits), 32'd0);
      chk("rst_at_lsd",  32'(bus.at_lsd),     32'd1);
      chk("rst_at_msd",  32'(bus.at_msd),     32'd0);
      rst = 1'b0;
      @(posedge sys_clk); #1;

      for (int i = 0; i < 9; i++) begin
         sb.push_back('{vt[i].prod, vt[i].win, vt[i].l});
         do_op(vt[i].a, vt[i].b, -1, -1);
      end

      for (int i = 0; i < 6; i++) begin
         logic [7:0] ra, rb;
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         sb.push_back(model(ra, rb));
         do_op(ra, rb, -1, -1);
      end

      sb.push_back(model(8'sh80, 8'sh80));
      do_op(8'h80, 8'h80, -1, -1);
      scroll(1'b1, 1'b0, 12'h638, "scroll_l1");
      scroll(1'b1, 1'b0, 12'h163, "scroll_l2");
      scroll(1'b1, 1'b0, 12'h163, "scroll_l3_sat");
      chk("at_msd_sat", 32'(bus.at_msd), 32'd1);
      scroll(1'b1, 1'b1, 12'h163, "scroll_both");
      scroll(1'b0, 1'b1, 12'h638, "scroll_r1");
      scroll(1'b0, 1'b1, 12'h384, "scroll_r2");
      scroll(1'b0, 1'b1, 12'h384, "scroll_r3_sat");
      chk("at_lsd_sat", 32'(bus.at_lsd), 32'd1);

      scroll(1'b1, 1'b0, 12'h638, "scroll_pre_commit");
      sb.push_back(model(8'sd127, 8'sd127));
      do_op(8'd127, 8'd127, 5, 23);
      chk("commit_pos_at_msd", 32'(bus.at_msd), 32'd0);

      bus.multiplier   = 8'd100;
      bus.multiplicand = 8'd100;
      bus.start        = 1'b1;
      @(posedge sys_clk); #1;
      bus.start = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      chk("mid_busy_before_rst", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(posedge sys_clk); #1;
      rst = 1'b0;
      chk("midrst_busy",    32'(bus.busy),       32'd0);
      chk("midrst_product", 32'(bus.product),    32'd0);
      chk("midrst_win",     32'(bus.win_digits), 32'd0);
      chk("midrst_at_lsd",  32'(bus.at_lsd),     32'd1);
      dn = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge sys_clk); #1;
         if (bus.done) dn++;
      end
      chk("midrst_no_done", 32'(dn), 32'd0);

      sb.push_back('{16'h0004, 12'h004, 18});
      do_op(8'd2, 8'd2, -1, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running required finished");
      $fatal(1, "timeout");
   end
endmodule
